// File: rtl/weight_loader.sv
// Streams weight words into the per-neuron weight memories of one layer, walking addresses then neurons.
// Latency: one cycle from an accepted beat to the registered write port; done pulses two cycles after the last beat.
// Backpressure: s_ready is high only in LOAD; the write port itself is never stalled.
module weight_loader #(
    parameter int data_width    = 16,
    parameter int address_width = 10,
    parameter int num_weights   = 784,
    parameter int num_neurons   = 30,
    parameter int sel_width     = 5,
    parameter int layer_no      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [sel_width-1:0]     start_neuron,
    input  logic [sel_width:0]       neuron_count,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [data_width-1:0]    s_data,
    output logic [num_neurons-1:0]   write_en,
    output logic [address_width-1:0] weight_address_w,
    output logic [data_width-1:0]    weight_in,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    if (((1 << address_width) < num_weights) || ((1 << sel_width) < num_neurons) || (layer_no < 0)) begin : g_bad_params
        $error("weight_loader: counter widths too narrow for the layer size");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam int cfg_w = sel_width + 2;
    localparam logic [address_width-1:0] last_addr_val = address_width'(num_weights - 1);

    state_t                   state, state_nxt;
    logic [sel_width-1:0]     nrn_cnt;
    logic [address_width-1:0] addr_cnt;
    logic [sel_width:0]       remaining;
    logic [num_neurons-1:0]   nrn_onehot;
    logic [cfg_w-1:0]         cfg_end;
    logic                     cfg_ok;
    logic                     accept;
    logic                     last_addr;
    logic                     last_beat;

    // Range check is done one bit wider than the operands so the sum cannot wrap.
    assign cfg_end   = cfg_w'(start_neuron) + cfg_w'(neuron_count);
    assign cfg_ok    = (neuron_count != '0) && (cfg_end <= cfg_w'(num_neurons));
    assign s_ready   = (state == LOAD);
    assign busy      = (state != IDLE);
    assign accept    = s_valid && s_ready;
    assign last_addr = (addr_cnt == last_addr_val);
    assign last_beat = accept && last_addr && (remaining == (sel_width+1)'(1));

    always_comb begin
        nrn_onehot = '0;
        for (int i = 0; i < num_neurons; i++) begin
            nrn_onehot[i] = (int'(nrn_cnt) == i);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && cfg_ok) state_nxt = LOAD;
            LOAD:    if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nrn_cnt          <= '0;
            addr_cnt         <= '0;
            remaining        <= '0;
            write_en         <= '0;
            weight_address_w <= '0;
            weight_in        <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            write_en <= '0;
            done     <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            nrn_cnt   <= start_neuron;
                            addr_cnt  <= '0;
                            remaining <= neuron_count;
                            error     <= 1'b0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        weight_in        <= s_data;
                        weight_address_w <= addr_cnt;
                        write_en         <= nrn_onehot;
                        // Neuron advance shares the edge with the address wrap: no gap between neurons.
                        if (last_addr) begin
                            addr_cnt  <= '0;
                            nrn_cnt   <= nrn_cnt + 1'b1;
                            remaining <= remaining - 1'b1;
                        end else begin
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: accepted beats push expected writes, the write port pops and compares them.
module tb_weight_loader;

    localparam int NW = 784;
    localparam int NN = 30;

    typedef struct packed {
        logic [NN-1:0] we;
        logic [9:0]    addr;
        logic [15:0]   dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  start_neuron;
    logic [5:0]  neuron_count;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [NN-1:0] write_en;
    logic [9:0]  weight_address_w;
    logic [15:0] weight_in;
    logic        busy;
    logic        done;
    logic        error;

    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_cnt   = 0;
    wr_t  exp_q[$];
    wr_t  mon_e;
    logic [15:0] mem [0:NN-1][0:NW-1];

    weight_loader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .start_neuron     (start_neuron),
        .neuron_count     (neuron_count),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .write_en         (write_en),
        .weight_address_w (weight_address_w),
        .weight_in        (weight_in),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] data_for(input int n, input int a, input logic [15:0] salt);
        return 16'((n << 10) | a) ^ salt;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_en", 64'(write_en), 64'(mon_e.we));
            check("wr_addr", 64'(weight_address_w), 64'(mon_e.addr));
            check("wr_data", 64'(weight_in), 64'(mon_e.dat));
        end else if (write_en != '0) begin
            check("spurious_wr", 64'(write_en), 64'd0);
        end
        if (write_en != '0) begin
            wr_cnt++;
            for (int i = 0; i < NN; i++) begin
                if (write_en[i] && weight_address_w < 10'(NW)) mem[i][weight_address_w] = weight_in;
            end
        end
    end

    task automatic do_start(input int sn, input int cnt, input bit exp_ok);
        start_neuron = 5'(sn);
        neuron_count = 6'(cnt);
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", 64'(busy), 64'(exp_ok));
        check("start_ready", 64'(s_ready), 64'(exp_ok));
        check("start_error", 64'(error), 64'(!exp_ok));
    endtask

    // Drives beats until stop_after (or the whole load) are accepted; optionally pulses an invalid start mid-load.
    task automatic run_load(input int sn, input int cnt, input int gap_pct, input logic [15:0] salt,
                            input int stop_after, input int mid_start_at);
        int  total;
        int  i     = 0;
        int  guard = 0;
        bit  acc;
        bit  pulsed = 0;
        wr_t e;
        total = (stop_after > 0) ? stop_after : cnt * NW;
        while (i < total && guard < total * 10 + 100) begin
            guard++;
            start = 1'b0;
            if (i == mid_start_at && !pulsed) begin
                pulsed       = 1;
                start        = 1'b1;
                start_neuron = 5'd0;
                neuron_count = 6'd0;
            end
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = data_for(sn + i / NW, i % NW, salt);
            end
            acc = s_valid && s_ready;
            @(posedge clk); #1;
            if (acc) begin
                e.we   = '0;
                e.we[sn + i / NW] = 1'b1;
                e.addr = 10'(i % NW);
                e.dat  = data_for(sn + i / NW, i % NW, salt);
                exp_q.push_back(e);
                i++;
            end
        end
        start   = 1'b0;
        s_valid = 1'b0;
        if (i < total) check("load_timeout", 64'(i), 64'(total));
    endtask

    task automatic check_done(input int exp_writes);
        @(negedge clk);
        check("last_busy", 64'(busy), 64'd1);
        check("last_ready", 64'(s_ready), 64'd0);
        check("last_done", 64'(done), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        check("write_count", 64'(wr_cnt), 64'(exp_writes));
        @(posedge clk); #1;
        check("done_clear", 64'(done), 64'd0);
        wr_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; start_neuron = '0; neuron_count = '0;
        s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_we", 64'(write_en), 64'd0);
        check("rst_addr", 64'(weight_address_w), 64'd0);
        check("rst_data", 64'(weight_in), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single neuron, data equals address.
        do_start(0, 1, 1);
        run_load(0, 1, 0, 16'h0000, 0, -1);
        check_done(NW);
        check("mem0_783", 64'(mem[0][783]), 64'd783);

        // Top two neurons: crossing into neuron 29.
        do_start(28, 2, 1);
        run_load(28, 2, 0, 16'h0000, 0, -1);
        check_done(2 * NW);
        check("mem29_0", 64'(mem[29][0]), 64'(data_for(29, 0, 16'h0000)));
        check("mem29_783", 64'(mem[29][783]), 64'(data_for(29, 783, 16'h0000)));

        // Random valid gaps.
        do_start(3, 2, 1);
        run_load(3, 2, 30, 16'h0000, 0, -1);
        check_done(2 * NW);

        // Invalid starts with the stream offered: nothing may be written.
        s_valid = 1'b1;
        do_start(29, 2, 0);
        do_start(0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check("inv_ready", 64'(s_ready), 64'd0);
        check("inv_error", 64'(error), 64'd1);
        s_valid = 1'b0;
        do_start(7, 1, 1);
        run_load(7, 1, 0, 16'h0F0F, 0, -1);
        check_done(NW);

        // Start pulsed mid-load is ignored.
        do_start(10, 1, 1);
        run_load(10, 1, 0, 16'h3C3C, 0, 300);
        check_done(NW);
        check("mid_error", 64'(error), 64'd0);

        // Reset after 100 beats aborts the load.
        do_start(5, 1, 1);
        run_load(5, 1, 0, 16'h1234, 100, -1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort_ready", 64'(s_ready), 64'd0);
        check("abort_we", 64'(write_en), 64'd0);
        check("abort_addr", 64'(weight_address_w), 64'd0);
        check("abort_data", 64'(weight_in), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_error", 64'(error), 64'd0);
        check("abort_writes", 64'(wr_cnt), 64'd100);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("keep_0", 64'(mem[5][0]), 64'(data_for(5, 0, 16'h1234)));
        check("keep_50", 64'(mem[5][50]), 64'(data_for(5, 50, 16'h1234)));
        check("keep_99", 64'(mem[5][99]), 64'(data_for(5, 99, 16'h1234)));
        wr_cnt = 0;
        do_start(5, 1, 1);
        run_load(5, 1, 0, 16'h0000, 0, -1);
        check_done(NW);
        check("reload_0", 64'(mem[5][0]), 64'(data_for(5, 0, 16'h0000)));
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
# weight_loader

Sequencer that writes weights into the per-neuron `weights_memory` instances of one layer in runtime-training mode (`pretrained` undefined). It takes a flat valid/ready stream of weight words and drives each memory's write port (`write_en`, `weight_address_w`, `weight_in`). Writes walk addresses 0..num_weights-1 for each neuron in turn, then advance to the next neuron. It sits between the host/config interface and the neuron array of a layer.

## Interface
- `data_width`, 16: weight word width; matches `weights_memory`.
- `address_width`, 10: write address width; must satisfy 2^address_width ≥ num_weights.
- `num_weights`, 784: weights per neuron.
- `num_neurons`, 30: neurons (memories) in the layer.
- `sel_width`, 5: neuron index width; must satisfy 2^sel_width ≥ num_neurons.
- `layer_no`, 1: layer identifier; informational only, no functional effect.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `start_neuron`  in  sel_width  first neuron to load.
- `neuron_count`  in  sel_width+1  number of consecutive neurons to load.
- `s_valid`  in  1  weight word valid.
- `s_ready`  out  1  loader accepts a word; a beat transfers when `s_valid && s_ready`.
- `s_data`  in  data_width  weight word.
- `write_en`  out  num_neurons  one-hot write enable; bit i drives neuron i's memory.
- `weight_address_w`  out  address_width  shared write address.
- `weight_in`  out  data_width  shared write data.
- `busy`  out  1  high in LOAD and DONE.
- `done`  out  1  one-cycle pulse after the final write.
- `error`  out  1  sticky flag for a rejected start.

## Operation
- Reset (`rst_n`=0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0: `s_ready`, `write_en`, `weight_address_w`, `weight_in`, `busy`, `done`, `error`.
  - Counters clear.
  - Reset mid-load aborts immediately. No further writes are issued. Memory contents already written are left as they are.
- States: IDLE, LOAD, DONE.
- IDLE, when `start`=1:
  - Valid config: `neuron_count` ≥ 1 and `start_neuron` + `neuron_count` ≤ num_neurons.
  - Valid: latch the config, set neuron counter = `start_neuron`, address counter = 0, remaining = `neuron_count`, clear `error`, go to LOAD.
  - Invalid: set `error`=1 and stay in IDLE.
- LOAD:
  - `s_ready`=1 every cycle.
  - Each accepted beat: register `s_data` into `weight_in`, the address counter into `weight_address_w`, and a one-hot of the neuron counter into `write_en`.
  - Address counter increments by 1. At num_weights-1 it wraps to 0, the neuron counter increments and remaining decrements.
  - The beat that completes the last neuron moves the state to DONE.
  - Cycles with no accepted beat: `write_en` = 0. `weight_address_w` and `weight_in` hold their last values.
- DONE:
  - `s_ready`=0.
  - The final write is on the output this cycle.
  - Next state is IDLE, with `done`=1 in that IDLE cycle.
- `start` during LOAD or DONE is ignored and does not set `error`.
- At most one `write_en` bit is high in any cycle.
- Each address of each loaded neuron is written exactly once per load.
- Neurons outside [start_neuron, start_neuron+neuron_count) are never written.

## Timing
- Beat accepted at edge N → `write_en`, `weight_address_w` and `weight_in` valid in cycle N+1 (one-cycle registered latency). The memory captures the write at edge N+1.
- Throughput is one word per cycle; bubbles occur only when `s_valid`=0.
- The write port has no backpressure; the memory accepts every write.
- `start` at edge S → `s_ready`=1 and `busy`=1 from cycle S+1.
- Last beat accepted at edge L:
  - Cycle L+1: final write on the outputs, state DONE, `s_ready`=0.
  - Cycle L+2: `done`=1, `busy`=0, IDLE.
  - A new `start` is accepted at edge L+2 at the earliest.
- A full load of k neurons takes k·num_weights accepted beats.
- The address-wrap beat and the neuron advance take effect on the same edge; no idle cycle is inserted between neurons.

## Test plan
- Reset, then `start`, `start_neuron`=0, `neuron_count`=1, with 784 back-to-back beats `s_data`=addr.
  - Required: `write_en`=0x1 for exactly 784 cycles, addresses 0..783 in order, `weight_in`=addr.
  - Required: `done` pulses 2 cycles after the last beat; a memory read of address 783 returns 783.
- `start_neuron`=28, `neuron_count`=2.
  - Required: beat 784 is written to neuron 29 at address 0; the last beat goes to neuron 29 at address 783.
  - Required: no `write_en` bit other than 28 or 29 is ever high.
- Random `s_valid` gaps.
  - Required: `write_en` is 0 in each bubble; the sequence of (neuron, address, data) writes is identical to the gap-free run.
- Invalid starts: `start_neuron`=29 with `neuron_count`=2; and `neuron_count`=0.
  - Required: `error`=1, state stays IDLE, `s_ready`=0, no writes.
  - Required: a following valid start clears `error`.
- `start` pulsed mid-load.
  - Required: it is ignored; the write count and the `done` timing are unchanged.
- `rst_n`=0 after 100 beats.
  - Required: on the next cycle all outputs are 0 and the state is IDLE.
  - Required: memory addresses 0..99 keep their written values; a new load restarts at address 0.
